// File: rtl/sdrx_cmd8x.sv
// Recovers a 48-bit short CMD response from the 8x oversampled CMD pin word.
// Result and flags are registered and appear with o_done one cycle after the end-bit or timeout strobe.
module sdrx_cmd8x #(
  parameter int NCR_MAX = 64,
  parameter int LGNCR   = 7
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_wide,
  input  logic        i_ckstb,
  input  logic [2:0]  i_phase,
  input  logic        i_rx_en,
  input  logic        i_crc_en,
  output logic        o_busy,
  output logic        o_done,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_arg,
  output logic        o_crc_err,
  output logic        o_frame_err,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

  localparam logic [LGNCR-1:0] NCR_LAST = LGNCR'(NCR_MAX - 1);
  localparam logic [LGNCR-1:0] NCR_TOP  = LGNCR'(NCR_MAX);

  state_t           state, state_nxt;
  logic [LGNCR-1:0] ncr;
  logic [5:0]       bitcnt;
  logic [45:0]      shreg;
  logic [6:0]       crc, crc_nxt;
  logic             crc_en;
  logic             b;

  assign b       = i_wide[i_phase];
  assign crc_nxt = {crc[5:0], 1'b0} ^ ((crc[6] ^ b) ? 7'h09 : 7'h00);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (i_rx_en) state_nxt = WAIT_START;
      // a start bit on the final allowed strobe takes priority over timeout
      WAIT_START: if (i_ckstb && (!b || ncr == NCR_LAST)) state_nxt = b ? DONE : RECV;
      RECV:       if (i_ckstb && bitcnt == 6'd47) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ncr         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      crc         <= '0;
      crc_en      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_cmd       <= '0;
      o_arg       <= '0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_busy <= (state_nxt != IDLE);
      o_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          ncr    <= '0;
          bitcnt <= '0;
          shreg  <= '0;
          crc    <= '0;
          if (i_rx_en) begin
            crc_en      <= i_crc_en;
            o_cmd       <= '0;
            o_arg       <= '0;
            o_crc_err   <= 1'b0;
            o_frame_err <= 1'b0;
            o_timeout   <= 1'b0;
          end
        end
        WAIT_START: if (i_ckstb) begin
          if (!b) begin
            bitcnt <= 6'd1;
            crc    <= crc_nxt;
          end else begin
            if (ncr != NCR_TOP) ncr <= ncr + LGNCR'(1);
            if (ncr == NCR_LAST) o_timeout <= 1'b1;
          end
        end
        RECV: if (i_ckstb) begin
          if (bitcnt == 6'd47) begin
            // shreg[45] is the transmission bit, [6:0] the received CRC
            o_cmd       <= shreg[44:39];
            o_arg       <= shreg[38:7];
            o_crc_err   <= crc_en && (shreg[6:0] != crc);
            o_frame_err <= shreg[45] || !b;
          end else begin
            shreg  <= {shreg[44:0], b};
            bitcnt <= bitcnt + 6'd1;
            if (bitcnt <= 6'd39) crc <= crc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrx_cmd8x.sv
// Directed bench for sdrx_cmd8x: frames are built with a bench CRC7 model or hand constants.
module tb_sdrx_cmd8x;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wide;
  logic        ckstb;
  logic [2:0]  phase;
  logic        rx_en;
  logic        crc_en;
  logic        busy, done, crc_err, frame_err, timeout;
  logic [5:0]  cmd;
  logic [31:0] arg;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int base = 0;
  logic [47:0] f;

  sdrx_cmd8x #(.NCR_MAX(64), .LGNCR(7)) dut (
    .i_clk(clk), .i_reset(rst), .i_wide(wide), .i_ckstb(ckstb), .i_phase(phase),
    .i_rx_en(rx_en), .i_crc_en(crc_en), .o_busy(busy), .o_done(done), .o_cmd(cmd),
    .o_arg(arg), .o_crc_err(crc_err), .o_frame_err(frame_err), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic tx, input logic [5:0] c, input logic [31:0] a,
                                           input logic endb);
    logic [39:0] d;
    d = {1'b0, tx, c, a};
    return {d, crc7(d), endb};
  endfunction

  // non-selected sub-samples carry the opposite value so a wrong index is visible
  task automatic strobe(input logic bv, input logic rx);
    logic [7:0] w;
    @(negedge clk);
    w = {8{~bv}};
    w[phase] = bv;
    wide  = w;
    ckstb = 1'b1;
    rx_en = rx;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ckstb = 1'b0;
    rx_en = 1'b0;
    wide  = 8'($urandom);
  endtask

  task automatic arm(input logic ce);
    @(negedge clk);
    ckstb  = 1'b0;
    rx_en  = 1'b1;
    crc_en = ce;
    @(negedge clk);
    rx_en  = 1'b0;
    crc_en = ~ce;
    base   = done_cnt;
    chk("arm.busy", 64'(busy), 64'd1);
  endtask

  task automatic high_strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      strobe(1'b1, 1'b0);
      for (int k = 1; k < gap; k++) idle_cycle();
    end
  endtask

  task automatic send_frame(input logic [47:0] fr, input int gap, input int nbits, input int pulse_at);
    for (int i = 47; i >= 48 - nbits; i--) begin
      strobe(fr[i], (47 - i) == pulse_at);
      if (i != 48 - nbits)
        for (int k = 1; k < gap; k++) idle_cycle();
    end
  endtask

  // rx_en is raised during the done cycle; it must not re-arm the receiver
  task automatic expect_done(input string t, input logic [5:0] c, input logic [31:0] a,
                             input logic ce, input logic fe, input logic to);
    @(negedge clk);
    ckstb = 1'b0;
    rx_en = 1'b1;
    wide  = 8'($urandom);
    chk({t, ".early_done"}, 64'(done_cnt), 64'(base));
    chk({t, ".done"}, 64'(done), 64'd1);
    chk({t, ".cmd"}, 64'(cmd), 64'(c));
    chk({t, ".arg"}, 64'(arg), 64'(a));
    chk({t, ".crc_err"}, 64'(crc_err), 64'(ce));
    chk({t, ".frame_err"}, 64'(frame_err), 64'(fe));
    chk({t, ".timeout"}, 64'(timeout), 64'(to));
    @(negedge clk);
    rx_en = 1'b0;
    chk({t, ".done_pulse"}, 64'(done), 64'd0);
    chk({t, ".busy_after"}, 64'(busy), 64'd0);
    chk({t, ".cmd_hold"}, 64'(cmd), 64'(c));
  endtask

  initial begin
    rst = 1'b1; wide = 8'hFF; ckstb = 1'b0; phase = 3'd0; rx_en = 1'b0; crc_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.cmd", 64'(cmd), 64'd0);
    chk("rst.arg", 64'(arg), 64'd0);
    chk("rst.crc_err", 64'(crc_err), 64'd0);
    chk("rst.frame_err", 64'(frame_err), 64'd0);
    chk("rst.timeout", 64'(timeout), 64'd0);

    // valid R1 to CMD17, strobe every 4th cycle with noise between
    phase = 3'd3;
    arm(1'b1);
    high_strobes(10, 4);
    send_frame(mk_frame(1'b0, 6'd17, 32'h0000_0900, 1'b1), 4, 48, -1);
    expect_done("r1", 6'd17, 32'h0000_0900, 1'b0, 1'b0, 1'b0);

    // R3 with CRC checking off, fixed all-ones CRC field
    phase = 3'd5;
    arm(1'b0);
    high_strobes(3, 1);
    f = {2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
    send_frame(f, 1, 48, -1);
    expect_done("r3", 6'h3F, 32'h80FF_8000, 1'b0, 1'b0, 1'b0);

    // arg bit 0 flipped, CRC of the original frame kept
    phase = 3'd0;
    arm(1'b1);
    high_strobes(2, 2);
    f = mk_frame(1'b0, 6'd17, 32'h0000_0900, 1'b1);
    f[8] = ~f[8];
    send_frame(f, 2, 48, -1);
    expect_done("crcerr", 6'd17, 32'h0000_0901, 1'b1, 1'b0, 1'b0);

    // transmission bit 1: bytes 40 00000000 carry the well-known CRC7 4A
    phase = 3'd7;
    arm(1'b1);
    high_strobes(1, 3);
    f = {8'h40, 32'h0000_0000, 7'h4A, 1'b1};
    send_frame(f, 3, 48, -1);
    expect_done("txbit", 6'd0, 32'h0, 1'b0, 1'b1, 1'b0);

    // end bit 0
    phase = 3'd6;
    arm(1'b1);
    send_frame(mk_frame(1'b0, 6'd2, 32'hDEAD_BEEF, 1'b0), 1, 48, -1);
    expect_done("endbit", 6'd2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

    // timeout after 64 high strobes; non-strobe noise must not count
    phase = 3'd1;
    arm(1'b1);
    high_strobes(63, 2);
    chk("to.busy63", 64'(busy), 64'd1);
    chk("to.done63", 64'(done), 64'd0);
    strobe(1'b1, 1'b0);
    expect_done("timeout", 6'd0, 32'h0, 1'b0, 1'b0, 1'b1);

    // start bit on strobe 64 wins over timeout
    phase = 3'd2;
    arm(1'b1);
    high_strobes(63, 1);
    send_frame(mk_frame(1'b0, 6'd8, 32'h0000_01AA, 1'b1), 1, 48, -1);
    expect_done("start64", 6'd8, 32'h0000_01AA, 1'b0, 1'b0, 1'b0);

    // reset at bit 20, then a clean re-arm with an ignored mid-frame rx_en
    phase = 3'd4;
    arm(1'b1);
    f = mk_frame(1'b0, 6'd55, 32'h1234_5678, 1'b1);
    send_frame(f, 1, 20, -1);
    @(negedge clk);
    rst = 1'b1;
    ckstb = 1'b1;
    wide = {8{f[27]}};
    @(negedge clk);
    rst = 1'b0;
    ckstb = 1'b0;
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    repeat (60) idle_cycle();
    chk("rst_mid.no_done", 64'(done_cnt), 64'(base));
    arm(1'b1);
    high_strobes(4, 1);
    send_frame(f, 1, 48, 10);
    expect_done("rearm", 6'd55, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
